// File: rtl/split_vector_loader.sv
// -----------------------------------------------------------------------------
// split_vector_loader
//
// Purpose:
//    Writer side of a split_N constraint checker. Serial WORD_W-bit words are
//    assembled into one TOTAL_W-bit assignment vector that drives the checker's
//    var_* inputs. Once the vector is complete, the block waits SETTLE_CYC cycles
//    and then samples the checker verdict chk_x. It returns one pass/fail result
//    per vector over a valid/ready handshake. It also keeps saturating pass and
//    fail counters.
//
// Ports:
//    clk        rising-edge clock for all logic
//    rst_n      synchronous reset, active-low
//    in_valid   stream word valid
//    in_ready   stream word accepted when in_valid & in_ready (LOAD state only)
//    in_data    stream word; word k lands at vec_out[k*WORD_W +: WORD_W]
//    in_last    marks the final word of a vector
//    vec_out    assembled assignment vector, to the checker
//    vec_valid  vec_out is complete and stable
//    chk_x      checker verdict (1 = constraints satisfied)
//    res_valid  result available
//    res_ready  result consumed when res_valid & res_ready
//    res_pass   sampled chk_x, forced to 0 on a framing error
//    res_err    framing error: in_last not aligned with the final word
//    pass_cnt   saturating count of passing results
//    fail_cnt   saturating count of failing results (framing errors included)
// -----------------------------------------------------------------------------
module split_vector_loader #(
   parameter int TOTAL_W    = 1536,
   parameter int WORD_W     = 16,
   parameter int SETTLE_CYC = 2,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WORD_W-1:0]  in_data,
   input  logic               in_last,
   output logic [TOTAL_W-1:0] vec_out,
   output logic               vec_valid,
   input  logic               chk_x,
   output logic               res_valid,
   input  logic               res_ready,
   output logic               res_pass,
   output logic               res_err,
   output logic [CNT_W-1:0]   pass_cnt,
   output logic [CNT_W-1:0]   fail_cnt
);

   localparam int NUM_WORDS = (TOTAL_W + WORD_W - 1) / WORD_W;
   // The final word may be narrower than WORD_W; its upper bits are dropped.
   localparam int LAST_W    = TOTAL_W - (NUM_WORDS - 1) * WORD_W;
   localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int SET_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic               pass_q, pass_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;

   logic               accept;
   logic               res_hs;
   logic               at_last;
   logic               settle_done;

   assign accept      = in_valid & in_ready;
   assign res_hs      = res_valid & res_ready;
   assign at_last     = (idx_q == LAST_IDX);
   assign settle_done = (settle_q == SET_LAST);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: begin
            if (accept) begin
               if (in_last && at_last) begin
                  state_d = ST_SETTLE;
               end else if (in_last || at_last) begin
                  // Frame ended early, or ran past the final word.
                  state_d = ST_REPORT;
               end
            end
         end
         ST_SETTLE: begin
            if (settle_done) begin
               state_d = ST_REPORT;
            end
         end
         ST_REPORT: begin
            if (res_hs) begin
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      vec_valid = 1'b0;
      res_valid = 1'b0;
      case (state_q)
         // Gated by rst_n so every output reads 0 while reset is held.
         ST_LOAD:   in_ready = rst_n;
         ST_SETTLE: vec_valid = 1'b1;
         ST_REPORT: begin
            res_valid = 1'b1;
            vec_valid = ~err_q;
         end
         default: begin
            in_ready  = 1'b0;
            vec_valid = 1'b0;
            res_valid = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Index, settle timer, result and counters
   // ------------------------------------------------------------------
   always_comb begin
      idx_d      = idx_q;
      settle_d   = settle_q;
      pass_d     = pass_q;
      err_d      = err_q;
      pass_cnt_d = pass_cnt_q;
      fail_cnt_d = fail_cnt_q;
      case (state_q)
         ST_LOAD: begin
            settle_d = '0;
            if (accept) begin
               if (in_last || at_last) begin
                  idx_d = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
               // A mismatch between in_last and the final-word position is a
               // framing error.
               if (in_last != at_last) begin
                  err_d  = 1'b1;
                  pass_d = 1'b0;
               end
            end
         end
         ST_SETTLE: begin
            if (settle_done) begin
               settle_d = '0;
               pass_d   = chk_x;
               err_d    = 1'b0;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         ST_REPORT: begin
            if (res_hs) begin
               if (pass_q) begin
                  if (pass_cnt_q != {CNT_W{1'b1}}) begin
                     pass_cnt_d = pass_cnt_q + CNT_W'(1);
                  end
               end else begin
                  if (fail_cnt_q != {CNT_W{1'b1}}) begin
                     fail_cnt_d = fail_cnt_q + CNT_W'(1);
                  end
               end
               pass_d = 1'b0;
               err_d  = 1'b0;
               idx_d  = '0;
            end
         end
         default: begin
            idx_d    = '0;
            settle_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q      <= '0;
         settle_q   <= '0;
         pass_q     <= 1'b0;
         err_q      <= 1'b0;
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
      end else begin
         idx_q      <= idx_d;
         settle_q   <= settle_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
      end
   end

   assign res_pass = pass_q;
   assign res_err  = err_q;
   assign pass_cnt = pass_cnt_q;
   assign fail_cnt = fail_cnt_q;

   // ------------------------------------------------------------------
   // Vector storage: one register per word slot. Each slot has its own
   // write enable, so bits that are not rewritten keep their old values.
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
         localparam int W_G = (gi == NUM_WORDS - 1) ? LAST_W : WORD_W;

         logic [W_G-1:0] word_q, word_d;

         always_comb begin
            word_d = word_q;
            if (accept && (idx_q == IDX_W'(gi))) begin
               word_d = in_data[W_G-1:0];
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               word_q <= '0;
            end else begin
               word_q <= word_d;
            end
         end

         assign vec_out[gi*WORD_W +: W_G] = word_q;
      end
   endgenerate

endmodule

// File: tb/tb_split_vector_loader.sv
module tb_split_vector_loader;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;

   // main instance (default parameters)
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [15:0]   in_data = '0;
   logic          in_last = 1'b0;
   logic [1535:0] vec_out;
   logic          vec_valid;
   logic          chk_x = 1'b0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic          res_pass;
   logic          res_err;
   logic [15:0]   pass_cnt;
   logic [15:0]   fail_cnt;

   // small instance: 20-bit vector of 8-bit words, 4-bit counters
   logic          s_in_valid = 1'b0;
   logic          s_in_ready;
   logic [7:0]    s_in_data = '0;
   logic          s_in_last = 1'b0;
   logic [19:0]   s_vec_out;
   logic          s_vec_valid;
   logic          s_chk_x = 1'b1;
   logic          s_res_valid;
   logic          s_res_ready = 1'b0;
   logic          s_res_pass;
   logic          s_res_err;
   logic [3:0]    s_pass_cnt;
   logic [3:0]    s_fail_cnt;

   int errors = 0;
   int checks = 0;

   logic [1535:0] exp_vec;

   always #5 clk = ~clk;

   split_vector_loader dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .vec_out(vec_out), .vec_valid(vec_valid), .chk_x(chk_x),
      .res_valid(res_valid), .res_ready(res_ready), .res_pass(res_pass), .res_err(res_err),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
   );

   split_vector_loader #(.TOTAL_W(20), .WORD_W(8), .SETTLE_CYC(1), .CNT_W(4)) dut_small (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_last(s_in_last),
      .vec_out(s_vec_out), .vec_valid(s_vec_valid), .chk_x(s_chk_x),
      .res_valid(s_res_valid), .res_ready(s_res_ready), .res_pass(s_res_pass), .res_err(s_res_err),
      .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt)
   );

   // Drive n words base+k; in_last on word last_at (-1 = never). Returns #1
   // after the edge that accepted the final word.
   task automatic send_words(input int n, input int last_at, input logic [15:0] base);
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b1;
         in_data  = base + 16'(k);
         in_last  = (k == last_at);
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready word %0d: got in_ready=%b want 1", k, in_ready);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, vec_valid, res_valid, res_pass, res_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 00000", {in_ready, vec_valid, res_valid, res_pass, res_err});
      end
      checks++;
      if (vec_out !== '0 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_data: got vec_lo=%h pass=%0d fail=%0d want 0", vec_out[63:0], pass_cnt, fail_cnt);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
      $display("test_reset done");
   endtask

   task automatic test_full_vector();
      chk_x = 1'b1;
      send_words(96, 95, 16'h0000);
      checks++;
      if ({vec_valid, res_valid, in_ready} !== 3'b100) begin
         errors++;
         $display("FAIL full_settle_flags: got %b want 100", {vec_valid, res_valid, in_ready});
      end
      for (int k = 0; k < 96; k++) exp_vec[k*16 +: 16] = 16'(k);
      checks++;
      if (vec_out[15:0] !== 16'h0000 || vec_out[1535:1520] !== 16'h005F) begin
         errors++;
         $display("FAIL full_ends: got lo=%h hi=%h want 0000 005f", vec_out[15:0], vec_out[1535:1520]);
      end
      checks++;
      if (vec_out !== exp_vec) begin
         errors++;
         $display("FAIL full_vector: got lo=%h want lo=%h", vec_out[127:0], exp_vec[127:0]);
      end
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_early_result: got res_valid=%b want 0", res_valid);
      end
      @(posedge clk); #1;
      checks++;
      if ({res_valid, res_pass, res_err, vec_valid, in_ready} !== 5'b11010) begin
         errors++;
         $display("FAIL full_result: got %b want 11010", {res_valid, res_pass, res_err, vec_valid, in_ready});
      end
      handshake();
      checks++;
      if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0 || {res_valid, vec_valid, in_ready} !== 3'b001) begin
         errors++;
         $display("FAIL full_after_hs: got pass=%0d fail=%0d flags=%b want 1 0 001",
                  pass_cnt, fail_cnt, {res_valid, vec_valid, in_ready});
      end
      $display("test_full_vector done");
   endtask

   task automatic test_framing();
      // early in_last on word 10
      send_words(11, 10, 16'h0100);
      checks++;
      if ({res_valid, res_pass, res_err, vec_valid} !== 4'b1010) begin
         errors++;
         $display("FAIL early_last_flags: got %b want 1010", {res_valid, res_pass, res_err, vec_valid});
      end
      checks++;
      if (vec_out[15:0] !== 16'h0100 || vec_out[175:160] !== 16'h010A || vec_out[191:176] !== 16'h000B) begin
         errors++;
         $display("FAIL early_last_data: got %h %h %h want 0100 010a 000b",
                  vec_out[15:0], vec_out[175:160], vec_out[191:176]);
      end
      handshake();
      checks++;
      if (fail_cnt !== 16'd1 || pass_cnt !== 16'd1) begin
         errors++;
         $display("FAIL early_last_cnt: got pass=%0d fail=%0d want 1 1", pass_cnt, fail_cnt);
      end
      // no in_last on word 95
      send_words(96, -1, 16'h0200);
      checks++;
      if ({res_valid, res_err, res_pass, vec_valid} !== 4'b1100 || vec_out[1535:1520] !== 16'h025F) begin
         errors++;
         $display("FAIL missing_last: got flags=%b hi=%h want 1100 025f",
                  {res_valid, res_err, res_pass, vec_valid}, vec_out[1535:1520]);
      end
      handshake();
      checks++;
      if (fail_cnt !== 16'd2) begin
         errors++;
         $display("FAIL missing_last_cnt: got fail=%0d want 2", fail_cnt);
      end
      // clean vector afterwards starts at word 0
      chk_x = 1'b1;
      send_words(96, 95, 16'h0300);
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 96; k++) exp_vec[k*16 +: 16] = 16'h0300 + 16'(k);
      checks++;
      if ({res_valid, res_pass, res_err, vec_valid} !== 4'b1101 || vec_out !== exp_vec) begin
         errors++;
         $display("FAIL recover: got flags=%b lo=%h want 1101 lo=%h",
                  {res_valid, res_pass, res_err, vec_valid}, vec_out[63:0], exp_vec[63:0]);
      end
      handshake();
      checks++;
      if (pass_cnt !== 16'd2 || fail_cnt !== 16'd2) begin
         errors++;
         $display("FAIL recover_cnt: got pass=%0d fail=%0d want 2 2", pass_cnt, fail_cnt);
      end
      $display("test_framing done");
   endtask

   task automatic test_settle_sample();
      // chk_x low through the sample edge, high just after it
      chk_x = 1'b0;
      send_words(96, 95, 16'h0500);
      @(posedge clk);
      @(posedge clk); #1;
      chk_x = 1'b1;
      checks++;
      if ({res_valid, res_pass} !== 2'b10) begin
         errors++;
         $display("FAIL sample_late_high: got %b want 10", {res_valid, res_pass});
      end
      @(posedge clk); #1;
      checks++;
      if (res_pass !== 1'b0) begin
         errors++;
         $display("FAIL sample_held: got res_pass=%b want 0", res_pass);
      end
      handshake();
      checks++;
      if (fail_cnt !== 16'd3 || pass_cnt !== 16'd2) begin
         errors++;
         $display("FAIL sample_fail_cnt: got pass=%0d fail=%0d want 2 3", pass_cnt, fail_cnt);
      end
      // chk_x high only across the sample edge
      chk_x = 1'b0;
      send_words(96, 95, 16'h0500);
      @(posedge clk); #1;
      chk_x = 1'b1;
      @(posedge clk); #1;
      chk_x = 1'b0;
      checks++;
      if ({res_valid, res_pass} !== 2'b11) begin
         errors++;
         $display("FAIL sample_pulse_high: got %b want 11", {res_valid, res_pass});
      end
      handshake();
      checks++;
      if (pass_cnt !== 16'd3) begin
         errors++;
         $display("FAIL sample_pass_cnt: got %0d want 3", pass_cnt);
      end
      chk_x = 1'b1;
      $display("test_settle_sample done");
   endtask

   task automatic test_back_pressure();
      int hold_bad;
      hold_bad = 0;
      send_words(96, 95, 16'h0600);
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
      in_last  = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if ({res_valid, res_pass, res_err, in_ready} !== 4'b1100 ||
             vec_out[15:0] !== 16'h0600 || pass_cnt !== 16'd3) hold_bad++;
      end
      checks++;
      if (hold_bad != 0) begin
         errors++;
         $display("FAIL hold_stable: got %0d bad cycles want 0", hold_bad);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      handshake();
      checks++;
      if (pass_cnt !== 16'd3 + 16'd1 || vec_out[15:0] !== 16'h0600) begin
         errors++;
         $display("FAIL hold_one_inc: got pass=%0d word0=%h want 4 0600", pass_cnt, vec_out[15:0]);
      end
      // res_ready while no result is pending is ignored
      res_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      res_ready = 1'b0;
      checks++;
      if (pass_cnt !== 16'd4 || fail_cnt !== 16'd3 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_ready: got pass=%0d fail=%0d res_valid=%b want 4 3 0", pass_cnt, fail_cnt, res_valid);
      end
      $display("test_back_pressure done");
   endtask

   task automatic test_reset_mid();
      send_words(50, -1, 16'h0700);
      in_valid = 1'b1;
      in_data  = 16'h0732;
      rst_n    = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({in_ready, vec_valid, res_valid, res_pass, res_err} !== 5'b0 ||
          vec_out !== '0 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset: got flags=%b lo=%h pass=%0d fail=%0d want all 0",
                  {in_ready, vec_valid, res_valid, res_pass, res_err}, vec_out[63:0], pass_cnt, fail_cnt);
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      send_words(96, 95, 16'h0800);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({res_valid, res_pass, res_err} !== 3'b110 || pass_cnt !== 16'd0 || vec_out[1535:1520] !== 16'h085F) begin
         errors++;
         $display("FAIL mid_reset_vector: got flags=%b pass=%0d hi=%h want 110 0 085f",
                  {res_valid, res_pass, res_err}, pass_cnt, vec_out[1535:1520]);
      end
      handshake();
      checks++;
      if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset_cnt: got pass=%0d fail=%0d want 1 0", pass_cnt, fail_cnt);
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_saturation();
      logic [3:0] exp_cnt;
      s_chk_x = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         for (int k = 0; k < 3; k++) begin
            s_in_valid = 1'b1;
            s_in_data  = (k == 0) ? 8'hA1 : (k == 1) ? 8'hB2 : 8'hC3;
            s_in_last  = (k == 2);
            @(posedge clk); #1;
         end
         s_in_valid = 1'b0;
         s_in_last  = 1'b0;
         @(posedge clk); #1;
         checks++;
         if ({s_res_valid, s_res_pass, s_res_err} !== 3'b110 || s_vec_out !== 20'h3B2A1) begin
            errors++;
            $display("FAIL sat_result %0d: got flags=%b vec=%h want 110 3b2a1",
                     i, {s_res_valid, s_res_pass, s_res_err}, s_vec_out);
         end
         s_res_ready = 1'b1;
         @(posedge clk); #1;
         s_res_ready = 1'b0;
         exp_cnt = (i > 15) ? 4'hF : 4'(i);
         checks++;
         if (s_pass_cnt !== exp_cnt || s_fail_cnt !== 4'd0) begin
            errors++;
            $display("FAIL sat_cnt %0d: got pass=%h fail=%h want %h 0", i, s_pass_cnt, s_fail_cnt, exp_cnt);
         end
      end
      $display("test_saturation done");
   endtask

   initial begin
      test_reset();
      test_full_vector();
      test_framing();
      test_settle_sample();
      test_back_pressure();
      test_reset_mid();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule
